// File: rtl/mu0_io.sv
// rtl/mu0_io.sv - MU0 memory-mapped I/O responder: transmit FIFO and countdown timer
//
// Ports:
//   Clk, Reset          clock; asynchronous active-high reset
//   Rd, Wr              CPU read / write strobes
//   Address[11:0]       CPU address; window is BASE..BASE+3
//   Data_in[15:0]       CPU write data
//   Data_out[15:0]      combinational read data, 0 unless Sel
//   Sel                 Rd high and Address inside the window
//   Tx_data[15:0]       FIFO head word, 0 when empty
//   Tx_valid            FIFO not empty
//   Tx_ready            consumer accepts the head word
//
// Register map (offset from BASE):
//   +0 TXDATA  W  push Data_in
//   +1 STATUS  R  {8'h0, running, expired, overflow, count[2:0], full, empty}
//   +2 TIMER   RW write loads and starts, read returns current count
//   +3 CLEAR   W  bit0 overflow, bit1 expired, bit2 stop timer

module mu0_io #(
    parameter logic [11:0] BASE  = 12'hFF0,
    parameter int          DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [11:0] Address,
    input  logic [15:0] Data_in,
    output logic [15:0] Data_out,
    output logic        Sel,
    output logic [15:0] Tx_data,
    output logic        Tx_valid,
    input  logic        Tx_ready
);

    localparam int PW = $clog2(DEPTH);

    logic          in_win;
    logic [1:0]    offset;
    logic          wr_en;
    logic          push, push_ok, pop;
    logic          timer_load, clr;
    logic          full, empty;

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          overflow;

    logic [15:0]   tcount;
    logic          running, expired;
    logic          stop;
    logic          expire_evt;
    logic [15:0]   status;

    assign in_win = (Address[11:2] == BASE[11:2]);
    assign offset = Address[1:0];
    assign wr_en  = Wr && in_win;

    assign push       = wr_en && (offset == 2'd0);
    assign timer_load = wr_en && (offset == 2'd2);
    assign clr        = wr_en && (offset == 2'd3);

    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));
    assign pop   = !empty && Tx_ready;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign push_ok = push && (!full || pop);

    assign Tx_valid = !empty;
    assign Tx_data  = empty ? 16'h0000 : mem[rd_ptr];

    // FIFO storage carries no reset; empty masks stale contents.
    always_ff @(posedge Clk) begin
        if (push_ok)
            mem[wr_ptr] <= Data_in;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (push && !push_ok)
                overflow <= 1'b1;
            else if (clr && Data_in[0])
                overflow <= 1'b0;
        end
    end

    // A stop request holds the count and suppresses that edge's decrement.
    assign stop       = clr && Data_in[2];
    assign expire_evt = (timer_load && (Data_in == 16'd0))
                      || (!timer_load && running && !stop && (tcount == 16'd1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tcount  <= 16'd0;
            running <= 1'b0;
            expired <= 1'b0;
        end else begin
            if (timer_load) begin
                tcount  <= Data_in;
                running <= (Data_in != 16'd0);
            end else if (stop) begin
                running <= 1'b0;
            end else if (running) begin
                tcount <= tcount - 16'd1;
                if (tcount == 16'd1)
                    running <= 1'b0;
            end
            // Expiry outranks a simultaneous clear request.
            if (expire_evt)
                expired <= 1'b1;
            else if (clr && Data_in[1])
                expired <= 1'b0;
        end
    end

    assign status = {8'h00, running, expired, overflow, 3'(count), full, empty};
    assign Sel    = Rd && in_win;

    always_comb begin
        Data_out = 16'h0000;
        if (Sel) begin
            case (offset)
                2'd1:    Data_out = status;
                2'd2:    Data_out = tcount;
                default: Data_out = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_mu0_io.sv
// tb/tb_mu0_io.sv - directed self-checking bench for mu0_io

module tb_mu0_io;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Rd = 1'b0;
    logic        Wr = 1'b0;
    logic [11:0] Address = 12'h000;
    logic [15:0] Data_in = 16'h0000;
    logic [15:0] Data_out;
    logic        Sel;
    logic [15:0] Tx_data;
    logic        Tx_valid;
    logic        Tx_ready = 1'b0;

    int total = 0;
    int bad = 0;

    logic [15:0] rdata;
    logic        rsel;
    logic [15:0] exp_q [4];

    mu0_io #(.BASE(12'hFF0), .DEPTH(4)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Rd       (Rd),
        .Wr       (Wr),
        .Address  (Address),
        .Data_in  (Data_in),
        .Data_out (Data_out),
        .Sel      (Sel),
        .Tx_data  (Tx_data),
        .Tx_valid (Tx_valid),
        .Tx_ready (Tx_ready)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [15:0] d);
        @(negedge Clk);
        Wr = 1'b1;
        Address = a;
        Data_in = d;
        @(posedge Clk);
        #1;
        Wr = 1'b0;
        Address = 12'h000;
        Data_in = 16'h0000;
    endtask

    task automatic rd(input logic [11:0] a, output logic [15:0] d, output logic s);
        Rd = 1'b1;
        Address = a;
        #1;
        d = Data_out;
        s = Sel;
        Rd = 1'b0;
        Address = 12'h000;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #12 Reset = 1'b0;

        // reset state and decode
        chk("rst_tx_valid", 16'(Tx_valid), 16'h0000);
        chk("rst_tx_data", Tx_data, 16'h0000);
        rd(12'hFF1, rdata, rsel);
        chk("rst_status", rdata, 16'h0001);
        chk("rst_sel_in", 16'(rsel), 16'h0001);
        rd(12'h0FF, rdata, rsel);
        chk("out_sel", 16'(rsel), 16'h0000);
        chk("out_data", rdata, 16'h0000);
        rd(12'hFF0, rdata, rsel);
        chk("txdata_rd_zero", rdata, 16'h0000);

        // fill, overflow, drain in order
        wr(12'hFF0, 16'h1111);
        wr(12'hFF0, 16'h2222);
        wr(12'hFF0, 16'h3333);
        wr(12'hFF0, 16'h4444);
        rd(12'hFF1, rdata, rsel);
        chk("full_status", rdata, 16'h0012);
        chk("head_1111", Tx_data, 16'h1111);
        wr(12'hFF0, 16'h5555);
        rd(12'hFF1, rdata, rsel);
        chk("ovf_status", rdata, 16'h0032);
        chk("head_hold", Tx_data, 16'h1111);
        Tx_ready = 1'b1;
        exp_q = '{16'h2222, 16'h3333, 16'h4444, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("drain1_%0d", i), Tx_data, exp_q[i]);
        end
        chk("drain1_empty", 16'(Tx_valid), 16'h0000);
        Tx_ready = 1'b0;
        wr(12'hFF3, 16'h0001);
        rd(12'hFF1, rdata, rsel);
        chk("ovf_cleared", rdata, 16'h0001);

        // full with simultaneous push and pop
        wr(12'hFF0, 16'h0101);
        wr(12'hFF0, 16'h0202);
        wr(12'hFF0, 16'h0303);
        wr(12'hFF0, 16'h0404);
        Tx_ready = 1'b1;
        wr(12'hFF0, 16'hAAAA);
        Tx_ready = 1'b0;
        rd(12'hFF1, rdata, rsel);
        chk("pushpop_status", rdata, 16'h0012);
        chk("pushpop_head", Tx_data, 16'h0202);
        Tx_ready = 1'b1;
        exp_q = '{16'h0303, 16'h0404, 16'hAAAA, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("drain2_%0d", i), Tx_data, exp_q[i]);
        end
        chk("drain2_empty", 16'(Tx_valid), 16'h0000);
        Tx_ready = 1'b0;

        // countdown to expiry
        wr(12'hFF2, 16'h0003);
        rd(12'hFF2, rdata, rsel);
        chk("tmr_3", rdata, 16'h0003);
        tick();
        rd(12'hFF2, rdata, rsel);
        chk("tmr_2", rdata, 16'h0002);
        tick();
        rd(12'hFF2, rdata, rsel);
        chk("tmr_1", rdata, 16'h0001);
        rd(12'hFF1, rdata, rsel);
        chk("tmr_running", rdata, 16'h0081);
        tick();
        rd(12'hFF2, rdata, rsel);
        chk("tmr_0", rdata, 16'h0000);
        rd(12'hFF1, rdata, rsel);
        chk("tmr_expired", rdata, 16'h0041);
        wr(12'hFF3, 16'h0002);
        rd(12'hFF1, rdata, rsel);
        chk("exp_cleared", rdata, 16'h0001);

        // stop holds the count
        wr(12'hFF2, 16'h0005);
        tick();
        tick();
        wr(12'hFF3, 16'h0004);
        rd(12'hFF2, rdata, rsel);
        chk("stop_count", rdata, 16'h0003);
        tick();
        rd(12'hFF2, rdata, rsel);
        chk("stop_hold", rdata, 16'h0003);
        rd(12'hFF1, rdata, rsel);
        chk("stop_status", rdata, 16'h0001);

        // reload on the expiry edge
        wr(12'hFF2, 16'h0002);
        tick();
        wr(12'hFF2, 16'h0007);
        rd(12'hFF2, rdata, rsel);
        chk("reload_count", rdata, 16'h0007);
        rd(12'hFF1, rdata, rsel);
        chk("reload_status", rdata, 16'h0081);
        wr(12'hFF3, 16'h0004);

        // clear-expired on the expiry edge: set wins
        wr(12'hFF2, 16'h0001);
        wr(12'hFF3, 16'h0002);
        rd(12'hFF1, rdata, rsel);
        chk("clr_vs_expire", rdata, 16'h0041);
        wr(12'hFF3, 16'h0002);

        // load zero expires immediately
        wr(12'hFF2, 16'h0000);
        rd(12'hFF1, rdata, rsel);
        chk("load0_status", rdata, 16'h0041);
        wr(12'hFF3, 16'h0002);

        // writes outside the window are ignored
        wr(12'hFF4, 16'h1234);
        wr(12'h0F0, 16'h5678);
        rd(12'hFF1, rdata, rsel);
        chk("outwin_status", rdata, 16'h0001);
        chk("outwin_valid", 16'(Tx_valid), 16'h0000);

        // asynchronous reset mid-operation
        wr(12'hFF0, 16'h7777);
        wr(12'hFF0, 16'h8888);
        wr(12'hFF2, 16'd100);
        chk("pre_rst_valid", 16'(Tx_valid), 16'h0001);
        #2 Reset = 1'b1;
        #1;
        chk("arst_valid", 16'(Tx_valid), 16'h0000);
        chk("arst_data", Tx_data, 16'h0000);
        rd(12'hFF1, rdata, rsel);
        chk("arst_status", rdata, 16'h0001);
        rd(12'hFF2, rdata, rsel);
        chk("arst_timer", rdata, 16'h0000);
        Reset = 1'b0;
        wr(12'hFF0, 16'h9999);
        chk("post_rst_head", Tx_data, 16'h9999);
        rd(12'hFF1, rdata, rsel);
        chk("post_rst_status", rdata, 16'h0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
